// File: rtl/amba_pkg.sv
// Shared APB types: FSM state encoding, phase constants, LFSR tap helper.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package amba_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SETUP  = 3'd1,
    ST_ACCESS = 3'd2,
    ST_NEXT   = 3'd3,
    ST_DONE   = 3'd4
  } apb_state_t;

  // Value of pwrite during each half of the self-test.
  localparam logic PHASE_WRITE = 1'b1;
  localparam logic PHASE_READ  = 1'b0;

  // Right-shifting Galois feedback masks for maximal-length sequences.
  function automatic logic [31:0] lfsr_taps(input int width);
    case (width)
      8:       return 32'h0000_00B8;  // x^8+x^6+x^5+x^4+1
      16:      return 32'h0000_B400;  // x^16+x^14+x^13+x^11+1
      default: return 32'h8020_0003;  // x^32+x^22+x^2+x+1
    endcase
  endfunction

endpackage

// File: rtl/apb_selftest_master_if.sv
// APB bus bundle between the self-test master and the muxed slave fabric.
// Latency: n/a (wires only).
// Backpressure: slave stretches ACCESS by holding pready low.
interface apb_selftest_master_if #(
  parameter int NUM_SLAVES = 2,
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 12
);
  logic [NUM_SLAVES-1:0] psel;
  logic                  penable;
  logic                  pwrite;
  logic [ADDR_W-1:0]     paddr;
  logic [DATA_W-1:0]     pwdata;
  logic [DATA_W-1:0]     prdata;
  logic                  pready;
  logic                  pslverr;

  modport master (
    output psel, penable, pwrite, paddr, pwdata,
    input  prdata, pready, pslverr
  );

  modport slave (
    input  psel, penable, pwrite, paddr, pwdata,
    output prdata, pready, pslverr
  );
endinterface

// File: rtl/lfsr_gen.sv
// Galois LFSR pattern source; load restores SEED, step advances one state.
// Latency: new value visible the cycle after load/step.
// Backpressure: holds its value whenever step is low.
module lfsr_gen
  import amba_pkg::*;
#(
  parameter int               WIDTH = 32,
  parameter logic [WIDTH-1:0] SEED  = '1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             step,
  output logic [WIDTH-1:0] value
);
  localparam logic [WIDTH-1:0] TAPS = WIDTH'(lfsr_taps(WIDTH));

  // Reseed on reset/load, otherwise shift right and fold in taps when the LSB falls out as 1.
  always_ff @(posedge clk) begin
    if (reset || load) begin
      value <= SEED;
    end else if (step) begin
      value <= {1'b0, value[WIDTH-1:1]} ^ (value[0] ? TAPS : '0);
    end
  end
endmodule

// File: rtl/apb_selftest_master.sv
// APB self-test: writes an LFSR pattern to every word of every slave, reads it back, counts errors.
// Latency: 3 cycles per zero-wait transfer, 6*NUM_SLAVES*NUM_WORDS cycles busy in total.
// Backpressure: ACCESS waits on pready, abandoning the transfer after TIMEOUT low cycles.
module apb_selftest_master
  import amba_pkg::*;
#(
  parameter int                NUM_SLAVES = 2,
  parameter int                NUM_WORDS  = 4,
  parameter int                DATA_W     = 32,
  parameter int                ADDR_W     = 12,
  parameter int                TIMEOUT    = 16,
  parameter logic [DATA_W-1:0] SEED       = '1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  apb_selftest_master_if.master apb,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic [7:0]           err_count
);
  localparam int SI_W  = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
  localparam int WI_W  = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
  localparam int WC_W  = $clog2(TIMEOUT) + 1;
  localparam int BYTES = DATA_W / 8;

  apb_state_t        state, state_nxt;
  logic [SI_W-1:0]   slave_idx;
  logic [WI_W-1:0]   word_idx;
  logic [WC_W-1:0]   wait_cnt;
  logic              write_phase;
  logic [DATA_W-1:0] pattern;
  logic              start_ok, timeout_hit, last_word, last_slave, last_xfer;
  logic              lfsr_load, lfsr_step;
  logic [1:0]        err_inc;
  logic [8:0]        err_sum;
  logic [7:0]        err_nxt;

  assign start_ok    = start && (state == ST_IDLE || state == ST_DONE);
  assign timeout_hit = (state == ST_ACCESS) && !apb.pready && (wait_cnt == WC_W'(TIMEOUT - 1));
  assign last_word   = (word_idx == WI_W'(NUM_WORDS - 1));
  assign last_slave  = (slave_idx == SI_W'(NUM_SLAVES - 1));
  assign last_xfer   = last_word && last_slave;

  // Write and read phases both start from SEED so the read side sees the same sequence.
  assign lfsr_load = start_ok || (state == ST_NEXT && last_xfer && write_phase == PHASE_WRITE);
  assign lfsr_step = (state == ST_NEXT) && !lfsr_load;

  lfsr_gen #(.WIDTH(DATA_W), .SEED(SEED)) u_lfsr (
    .clk   (clk),
    .reset (reset),
    .load  (lfsr_load),
    .step  (lfsr_step),
    .value (pattern)
  );

  // Error contributions of the current ACCESS cycle, then a saturating add.
  always_comb begin
    err_inc = 2'd0;
    if (state == ST_ACCESS) begin
      if (apb.pready) begin
        err_inc = {1'b0, apb.pslverr}
                + {1'b0, (write_phase == PHASE_READ) && (apb.prdata != pattern)};
      end else if (timeout_hit) begin
        err_inc = 2'd1;
      end
    end
    err_sum = {1'b0, err_count} + {7'd0, err_inc};
    err_nxt = err_sum[8] ? 8'hFF : err_sum[7:0];
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  // Next-state decode.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE, ST_DONE: if (start) state_nxt = ST_SETUP;
      ST_SETUP:         state_nxt = ST_ACCESS;
      ST_ACCESS:        if (apb.pready || timeout_hit) state_nxt = ST_NEXT;
      ST_NEXT:          state_nxt = (last_xfer && write_phase == PHASE_READ) ? ST_DONE : ST_SETUP;
      default:          state_nxt = ST_IDLE;
    endcase
  end

  // APB outputs: select only in SETUP/ACCESS, address and data only while a test is running.
  always_comb begin
    apb.psel    = '0;
    apb.penable = 1'b0;
    apb.paddr   = '0;
    apb.pwdata  = '0;
    apb.pwrite  = write_phase;
    if (state == ST_SETUP || state == ST_ACCESS) begin
      apb.psel    = NUM_SLAVES'(1) << slave_idx;
      apb.penable = (state == ST_ACCESS);
    end
    if (state != ST_IDLE && state != ST_DONE) begin
      apb.paddr  = ADDR_W'(32'(word_idx) * 32'(BYTES));
      apb.pwdata = pattern;
    end
  end

  // Indices, wait counter, error count and status flags.
  always_ff @(posedge clk) begin
    if (reset) begin
      slave_idx   <= '0;
      word_idx    <= '0;
      wait_cnt    <= '0;
      write_phase <= 1'b0;
      err_count   <= 8'd0;
      busy        <= 1'b0;
      done        <= 1'b0;
      pass        <= 1'b0;
    end else begin
      if (start_ok) begin
        slave_idx   <= '0;
        word_idx    <= '0;
        write_phase <= PHASE_WRITE;
        err_count   <= 8'd0;
        busy        <= 1'b1;
        done        <= 1'b0;
        pass        <= 1'b0;
      end
      if (state == ST_SETUP) wait_cnt <= '0;
      if (state == ST_ACCESS) begin
        if (!apb.pready) wait_cnt <= wait_cnt + 1'b1;
        err_count <= err_nxt;
      end
      if (state == ST_NEXT) begin
        if (last_word) begin
          word_idx <= '0;
          if (last_slave) begin
            slave_idx <= '0;
            if (write_phase == PHASE_WRITE) begin
              write_phase <= PHASE_READ;
            end else begin
              busy <= 1'b0;
              done <= 1'b1;
              pass <= (err_count == 8'd0);
            end
          end else begin
            slave_idx <= slave_idx + 1'b1;
          end
        end else begin
          word_idx <= word_idx + 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_apb_selftest_master.sv
// Bench for apb_selftest_master: two-slave memory model with configurable waits/faults.
// Latency: n/a.
// Backpressure: slave 1 may stall or never answer, per scenario.
module tb_apb_selftest_master;
  logic clk = 1'b0;
  logic reset, start;
  logic busy, done, pass;
  logic [7:0] err_count;

  apb_selftest_master_if #(.NUM_SLAVES(2), .DATA_W(32), .ADDR_W(12)) bus ();

  apb_selftest_master dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .apb       (bus),
    .busy      (busy),
    .done      (done),
    .pass      (pass),
    .err_count (err_count)
  );

  always #5 clk = ~clk;

  // ---------------- slave memory model ----------------
  int   cfg_wait1, exp_len1;
  bit   cfg_hang1, cfg_corrupt, cfg_slverr0;
  logic [31:0] mem [2][4];
  int   wcnt;
  logic s1;
  logic [1:0] widx;

  assign s1   = bus.psel[1];
  assign widx = bus.paddr[3:2];
  assign bus.pready  = s1 ? (!cfg_hang1 && wcnt >= cfg_wait1) : 1'b1;
  assign bus.prdata  = mem[s1][widx] ^ ((cfg_corrupt && !s1 && widx == 2'd2) ? 32'd1 : 32'd0);
  assign bus.pslverr = cfg_slverr0 && bus.psel[0] && bus.pready;

  always @(posedge clk) begin
    if (bus.penable && !bus.pready) wcnt <= wcnt + 1;
    else                            wcnt <= 0;
    if (bus.penable && bus.pready && bus.pwrite) mem[s1][widx] <= bus.pwdata;
  end

  // ---------------- protocol monitor ----------------
  int   stab_bad = 0, len_bad = 0, s1_acc = 0, acc_len = 0;
  bit   in_acc = 0;
  logic [1:0]  h_sel, prev_sel = '0;
  logic        h_wr, prev_pen = 1'b0;
  logic [11:0] h_addr;
  logic [31:0] h_data;

  always @(negedge clk) begin
    if (bus.penable) begin
      if (in_acc) begin
        if (bus.psel !== h_sel || bus.paddr !== h_addr || bus.pwdata !== h_data || bus.pwrite !== h_wr)
          stab_bad++;
        acc_len++;
      end else begin
        if (prev_pen !== 1'b0 || prev_sel !== bus.psel || bus.psel == 2'b00) stab_bad++;
        in_acc = 1; acc_len = 1;
        h_sel = bus.psel; h_addr = bus.paddr; h_data = bus.pwdata; h_wr = bus.pwrite;
      end
    end else if (in_acc) begin
      in_acc = 0;
      if (h_sel == 2'b10) begin
        s1_acc++;
        if (acc_len != exp_len1) len_bad++;
      end
    end
    prev_pen = bus.penable;
    prev_sel = bus.psel;
  end

  // ---------------- checking helpers ----------------
  int checks = 0, errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, " psel"},      64'(bus.psel),    64'd0);
    check({tag, " penable"},   64'(bus.penable), 64'd0);
    check({tag, " pwrite"},    64'(bus.pwrite),  64'd0);
    check({tag, " paddr"},     64'(bus.paddr),   64'd0);
    check({tag, " pwdata"},    64'(bus.pwdata),  64'd0);
    check({tag, " busy"},      64'(busy),        64'd0);
    check({tag, " done"},      64'(done),        64'd0);
    check({tag, " pass"},      64'(pass),        64'd0);
    check({tag, " err_count"}, 64'(err_count),   64'd0);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Count busy cycles until done; optionally re-pulse start mid-run at cycle pulse_at.
  task automatic wait_done(input int pulse_at, output int cyc);
    int n = 0;
    cyc = 0;
    while (!done && n < 4000) begin
      if (busy) cyc++;
      start = (n == pulse_at);
      @(negedge clk);
      n++;
    end
    start = 1'b0;
    if (!done) begin
      checks++; errors++;
      $display("FAIL wait_done: timed out after %0d cycles, done=%0b required 1", n, done);
    end
  endtask

  typedef struct {
    int wait1; bit hang1; bit corrupt; bit slverr0;
    int exp_len1; int exp_err; bit exp_pass; int exp_cycles;
  } vec_t;

  vec_t vecs[5];

  initial begin
    int cyc, s1_0, len_0, stab_0, n;

    // wait1 hang corrupt slverr | len1 err pass busy-cycles
    vecs[0] = '{0, 0, 0, 0,  1, 0, 1,  48};  // zero-wait baseline
    vecs[1] = '{2, 0, 0, 0,  3, 0, 1,  64};  // slave 1: 2 wait states each access (+16)
    vecs[2] = '{0, 0, 1, 0,  1, 1, 0,  48};  // slave 0 word 2 read corrupted
    vecs[3] = '{0, 1, 0, 0, 16, 8, 0, 168};  // slave 1 never ready: 8 timeouts (+8*15)
    vecs[4] = '{0, 0, 0, 1,  1, 8, 0,  48};  // slave 0 flags pslverr on all 8 accesses

    cfg_wait1 = 0; cfg_hang1 = 0; cfg_corrupt = 0; cfg_slverr0 = 0; exp_len1 = 1;

    // Reset held together with start: reset wins.
    reset = 1'b1; start = 1'b1;
    repeat (2) @(negedge clk);
    check_reset_outputs("por");
    reset = 1'b0; start = 1'b0;
    @(negedge clk);
    check("idle busy", 64'(busy), 64'd0);

    // Table-driven scenarios.
    for (int i = 0; i < 5; i++) begin
      cfg_wait1 = vecs[i].wait1; cfg_hang1 = vecs[i].hang1;
      cfg_corrupt = vecs[i].corrupt; cfg_slverr0 = vecs[i].slverr0;
      exp_len1 = vecs[i].exp_len1;
      s1_0 = s1_acc; len_0 = len_bad; stab_0 = stab_bad;
      pulse_start();
      wait_done(-1, cyc);
      @(negedge clk);
      check($sformatf("v%0d err_count", i), 64'(err_count), 64'(vecs[i].exp_err));
      check($sformatf("v%0d pass", i),      64'(pass),      64'(vecs[i].exp_pass));
      check($sformatf("v%0d done", i),      64'(done),      64'd1);
      check($sformatf("v%0d busy_cycles", i), 64'(cyc),     64'(vecs[i].exp_cycles));
      check($sformatf("v%0d s1_accesses", i), 64'(s1_acc - s1_0), 64'd8);
      check($sformatf("v%0d s1_access_len", i), 64'(len_bad - len_0), 64'd0);
      check($sformatf("v%0d apb_stability", i), 64'(stab_bad - stab_0), 64'd0);
    end

    // Written pattern: seed, then one right-shift Galois step (0x7FFFFFFF ^ 0x80200003).
    check("mem s0w0", 64'(mem[0][0]), 64'hFFFF_FFFF);
    check("mem s0w1", 64'(mem[0][1]), 64'hFFDF_FFFC);

    // Reset in the ACCESS of write 3 (slave 0, word 3, paddr 12), then full rerun.
    cfg_wait1 = 0; cfg_hang1 = 0; cfg_corrupt = 0; cfg_slverr0 = 0; exp_len1 = 1;
    pulse_start();
    n = 0;
    while (!(bus.penable && bus.pwrite && bus.psel == 2'b01 && bus.paddr == 12'd12) && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("reach write3 access", 64'(n < 200), 64'd1);
    reset = 1'b1;
    @(negedge clk);
    check_reset_outputs("midreset");
    reset = 1'b0;
    @(negedge clk);
    pulse_start();
    wait_done(-1, cyc);
    check("rerun busy_cycles", 64'(cyc), 64'd48);
    check("rerun pass", 64'(pass), 64'd1);

    // start while busy is ignored: run length unchanged.
    cfg_corrupt = 1;
    pulse_start();
    wait_done(10, cyc);
    check("busy start busy_cycles", 64'(cyc), 64'd48);
    check("busy start err_count", 64'(err_count), 64'd1);

    // start in DONE restarts with err_count cleared.
    cfg_corrupt = 0;
    pulse_start();
    check("restart err_count", 64'(err_count), 64'd0);
    check("restart busy", 64'(busy), 64'd1);
    check("restart done", 64'(done), 64'd0);
    check("restart pass", 64'(pass), 64'd0);
    wait_done(-1, cyc);
    check("restart busy_cycles", 64'(cyc), 64'd48);
    check("restart final pass", 64'(pass), 64'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/apb_selftest_master.md
APB_SELFTEST_MASTER -- requirements
Module: apb_selftest_master

Interface
REQ-001 Parameter NUM_SLAVES, default 2: number of APB slaves exercised, range 1..8.
REQ-002 Parameter NUM_WORDS, default 4: words written then read back per slave, range 1..256.
REQ-003 Parameter DATA_W, default 32: APB data width, 8, 16 or 32.
REQ-004 Parameter ADDR_W, default 12: APB address width.
REQ-005 Parameter TIMEOUT, default 16: maximum ACCESS cycles with PREADY low before the transfer is abandoned.
REQ-006 Parameter SEED, default all-ones: nonzero LFSR seed for the data pattern.
REQ-007 clk  in  1  sole clock; all logic is rising-edge triggered.
REQ-008 reset  in  1  synchronous, active-high reset.
REQ-009 start  in  1  one-cycle request to run the test; honoured only in IDLE or DONE.
REQ-010 psel  out  NUM_SLAVES  one-hot slave select.
REQ-011 penable  out  1  APB enable.
REQ-012 pwrite  out  1  1 = write phase, 0 = read phase.
REQ-013 paddr  out  ADDR_W  word address, equal to word_index*(DATA_W/8).
REQ-014 pwdata  out  DATA_W  LFSR pattern word.
REQ-015 prdata  in  DATA_W  read data, already muxed by the interconnect.
REQ-016 pready  in  1  slave ready.
REQ-017 pslverr  in  1  slave error, sampled with pready.
REQ-018 busy, done, pass  out  1 each  running; finished (level); finished with zero errors.
REQ-019 err_count  out  8  saturating count of mismatches, slave errors and timeouts.

Function
REQ-020 The FSM SHALL have states IDLE, SETUP, ACCESS, NEXT and DONE.
REQ-021 In IDLE/DONE, start=1 SHALL move to SETUP next cycle, clear err_count, reseed the LFSR, zero the indices, set pwrite=1, and set busy=1, done=0 and pass=0.
REQ-022 SETUP SHALL last exactly one cycle with psel=one-hot(slave_idx) and penable=0, then go to ACCESS.
REQ-023 ACCESS SHALL hold penable=1 and keep psel, paddr, pwrite and pwdata stable until pready=1 or the timeout expires.
REQ-024 On completion in ACCESS: pslverr=1 SHALL add 1 to err_count; in the read phase, prdata!=expected pattern SHALL add 1 (at most 1 per transfer); then go to NEXT.
REQ-025 After TIMEOUT consecutive ACCESS cycles with pready=0, the transfer SHALL be abandoned, err_count incremented, and the FSM SHALL go to NEXT.
REQ-026 NEXT (one cycle, psel=0, penable=0) SHALL advance the LFSR and word_idx; word_idx wraps at NUM_WORDS, incrementing slave_idx; slave_idx wraps at NUM_SLAVES, ending the phase.
REQ-027 End of write phase SHALL reseed the LFSR, set pwrite=0 and return to SETUP; end of read phase SHALL go to DONE.
REQ-028 DONE SHALL set busy=0, done=1 and pass=(err_count==0), held until the next start or reset.
REQ-029 err_count SHALL saturate at 255 and never wrap.
REQ-030 start while busy=1 SHALL be ignored.
REQ-031 The LFSR SHALL be a maximal-length DATA_W-bit Galois LFSR; the write and read phases use an identical sequence.
REQ-032 With zero wait states, each transfer SHALL take 3 cycles (SETUP, ACCESS, NEXT), so busy lasts 6*NUM_SLAVES*NUM_WORDS cycles.

Reset
REQ-033 reset=1 SHALL, at the next rising edge, force IDLE, psel=0, penable=0, pwrite=0, paddr=0, pwdata=0, busy=0, done=0, pass=0 and err_count=0, including mid-transfer.
REQ-034 reset SHALL take priority over start in the same cycle.

Structure
REQ-035 The state enum and APB phase constants SHALL live in the shared package amba_pkg.
REQ-036 The LFSR SHALL be a separate sub-module, lfsr_gen (parameter WIDTH, SEED; inputs load and step).

Verification
REQ-037 Zero-wait memory model, defaults, start pulse -> 8 writes then 8 reads, busy for 48 cycles, done=1, pass=1, err_count=0.
REQ-038 Slave 1 holds pready low 2 cycles per access -> every ACCESS phase for slave 1 lasts 3 cycles, pass=1, and pwdata/paddr stay stable throughout.
REQ-039 Memory corrupts slave 0 word 2 (bit 0 flipped) -> err_count=1, pass=0.
REQ-040 Slave 1 never asserts pready -> each of its 8 accesses times out after 16 cycles, err_count=8, done=1.
REQ-041 reset asserted during ACCESS of write 3 -> next cycle all outputs are at reset values; a new start reruns the full sequence.
REQ-042 start pulsed while busy, and again in DONE -> ignored while busy; in DONE it restarts with err_count cleared.
